// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-to-execute stage bus.
// Carries the decode-side valid/ready handshake and payload, the execute-side
// valid/ready handshake and registered payload, flush, register-file writeback
// and the bubble counter.
//   master : drives decode payload, ex_ready, flush, writeback; observes stage outputs
//   slave  : the pipeline register itself
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) ();
    // decode side
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rdata1;
    logic [XLEN-1:0] id_rdata2;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            id_alu_src;
    logic            id_branch;
    logic [1:0]      id_alu_op;
    logic [3:0]      id_funct;

    // execute side
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rdata1;
    logic [XLEN-1:0] ex_rdata2;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [1:0]      ex_alu_op;
    logic [3:0]      ex_funct;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_alu_src;
    logic            ex_branch;

    // control, writeback and status
    logic             flush;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output id_valid, id_pc, id_imm, id_rdata1, id_rdata2, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_branch, id_alu_op, id_funct,
               ex_ready, flush, wb_reg_write, wb_rd, wb_data,
        input  id_ready, ex_valid, ex_pc, ex_imm, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2,
               ex_rd, ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rdata1, id_rdata2, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_branch, id_alu_op, id_funct,
               ex_ready, flush, wb_reg_write, wb_rd, wb_data,
        output id_ready, ex_valid, ex_pc, ex_imm, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2,
               ex_rd, ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register.
// Captures decode operands/control under valid/ready, inserts a bubble on a
// load-use dependency, drops contents on flush, and keeps held operands
// coherent with register-file writeback.
// Ports:
//   clk    : clock, posedge
//   rst_n  : asynchronous active-low reset
//   bus    : id_ex_stage_if.slave (decode handshake/payload, execute handshake/
//            payload, flush, writeback, bubble_count)
// id_ready is combinational from the current inputs and held state.
module id_ex_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rdata1;
        logic [XLEN-1:0]  rdata2;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [1:0]       alu_op;
        logic [3:0]       funct;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             alu_src;
        logic             branch;
    } payload_t;

    payload_t         pl_q, pl_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hazard_c;
    logic id_ready_c;
    logic capture_c;
    logic wb_en_c;

    // Load-use detection and handshake qualification
    always_comb begin
        hazard_c   = bus.id_valid & valid_q & pl_q.mem_read & (pl_q.rd != '0) &
                     ((bus.id_use_rs1 & (bus.id_rs1 == pl_q.rd)) |
                      (bus.id_use_rs2 & (bus.id_rs2 == pl_q.rd)));
        id_ready_c = ~bus.flush & ~hazard_c & (~valid_q | bus.ex_ready);
        capture_c  = bus.id_valid & id_ready_c;
        // x0 is hard-wired, so a writeback to it never overrides an operand
        wb_en_c    = bus.wb_reg_write & (bus.wb_rd != '0);
    end

    assign bus.id_ready = id_ready_c;

    // Next-state: flush > capture > bubble > drain > hold
    always_comb begin
        pl_d    = pl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture_c) begin
            valid_d        = 1'b1;
            pl_d.pc        = bus.id_pc;
            pl_d.imm       = bus.id_imm;
            pl_d.rdata1    = bus.id_rdata1;
            pl_d.rdata2    = bus.id_rdata2;
            pl_d.rs1       = bus.id_rs1;
            pl_d.rs2       = bus.id_rs2;
            pl_d.rd        = bus.id_rd;
            pl_d.alu_op    = bus.id_alu_op;
            pl_d.funct     = bus.id_funct;
            pl_d.reg_write = bus.id_reg_write;
            pl_d.mem_read  = bus.id_mem_read;
            pl_d.mem_write = bus.id_mem_write;
            pl_d.mem_to_reg= bus.id_mem_to_reg;
            pl_d.alu_src   = bus.id_alu_src;
            pl_d.branch    = bus.id_branch;
            // Register file is written this same edge; its read data is stale
            if (wb_en_c && (bus.wb_rd == bus.id_rs1)) pl_d.rdata1 = bus.wb_data;
            if (wb_en_c && (bus.wb_rd == bus.id_rs2)) pl_d.rdata2 = bus.wb_data;
        end else if (hazard_c && bus.ex_ready) begin
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled instruction picks up results written while it waits
            if (wb_en_c && (bus.wb_rd == pl_q.rs1)) pl_d.rdata1 = bus.wb_data;
            if (wb_en_c && (bus.wb_rd == pl_q.rs2)) pl_d.rdata2 = bus.wb_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pl_q    <= pl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_pc         = pl_q.pc;
    assign bus.ex_imm        = pl_q.imm;
    assign bus.ex_rdata1     = pl_q.rdata1;
    assign bus.ex_rdata2     = pl_q.rdata2;
    assign bus.ex_rs1        = pl_q.rs1;
    assign bus.ex_rs2        = pl_q.rs2;
    assign bus.ex_rd         = pl_q.rd;
    assign bus.ex_alu_op     = pl_q.alu_op;
    assign bus.ex_funct      = pl_q.funct;
    assign bus.ex_reg_write  = pl_q.reg_write;
    assign bus.ex_mem_read   = pl_q.mem_read;
    assign bus.ex_mem_write  = pl_q.mem_write;
    assign bus.ex_mem_to_reg = pl_q.mem_to_reg;
    assign bus.ex_alu_src    = pl_q.alu_src;
    assign bus.ex_branch     = pl_q.branch;
    assign bus.bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with a transaction-level
// reference model. A narrow bubble counter is used so saturation is reachable.
module tb_id_ex_stage;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rdata1;
        logic [63:0] rdata2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic [1:0]  alu_op;
        logic [3:0]  funct;
    } ins_t;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cnt;
        ins_t             ins;
    } mstate_t;

    logic clk;
    logic rst_n;
    logic chk_en;

    // stimulus
    logic        v;
    ins_t        cur;
    logic        exr;
    logic        fl;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [63:0] wbd;

    int total;
    int bad;

    mstate_t st;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.id_valid      = v;
    assign bus.id_pc         = cur.pc;
    assign bus.id_imm        = cur.imm;
    assign bus.id_rdata1     = cur.rdata1;
    assign bus.id_rdata2     = cur.rdata2;
    assign bus.id_rs1        = cur.rs1;
    assign bus.id_rs2        = cur.rs2;
    assign bus.id_rd         = cur.rd;
    assign bus.id_use_rs1    = cur.use1;
    assign bus.id_use_rs2    = cur.use2;
    assign bus.id_reg_write  = cur.reg_write;
    assign bus.id_mem_read   = cur.mem_read;
    assign bus.id_mem_write  = cur.mem_write;
    assign bus.id_mem_to_reg = cur.mem_to_reg;
    assign bus.id_alu_src    = cur.alu_src;
    assign bus.id_branch     = cur.branch;
    assign bus.id_alu_op     = cur.alu_op;
    assign bus.id_funct      = cur.funct;
    assign bus.ex_ready      = exr;
    assign bus.flush         = fl;
    assign bus.wb_reg_write  = wbw;
    assign bus.wb_rd         = wbrd;
    assign bus.wb_data       = wbd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t alu(input logic [63:0] pc, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [63:0] d1, input logic [63:0] d2);
        ins_t i;
        i           = '0;
        i.pc        = pc;
        i.imm       = pc ^ 64'h5a;
        i.rdata1    = d1;
        i.rdata2    = d2;
        i.rs1       = rs1;
        i.rs2       = rs2;
        i.rd        = rd;
        i.use1      = 1'b1;
        i.use2      = 1'b1;
        i.reg_write = 1'b1;
        i.alu_op    = 2'b10;
        return i;
    endfunction

    function automatic ins_t ld(input logic [63:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
        ins_t i;
        i            = '0;
        i.pc         = pc;
        i.imm        = 64'd8;
        i.rdata1     = 64'h1000;
        i.rs1        = rs1;
        i.rd         = rd;
        i.use1       = 1'b1;
        i.reg_write  = 1'b1;
        i.mem_read   = 1'b1;
        i.mem_to_reg = 1'b1;
        i.alu_src    = 1'b1;
        i.funct      = 4'b0011;
        return i;
    endfunction

    // Does the decode instruction need the value a load in EX has not produced yet?
    function automatic logic waits_on_load(input mstate_t s);
        if (!v || !s.valid || !s.ins.mem_read || s.ins.rd == 5'd0) return 1'b0;
        return (cur.use1 && cur.rs1 == s.ins.rd) || (cur.use2 && cur.rs2 == s.ins.rd);
    endfunction

    function automatic logic accepts(input mstate_t s);
        return !fl && !waits_on_load(s) && (!s.valid || exr);
    endfunction

    function automatic logic [63:0] wb_fix(input logic [4:0] rs, input logic [63:0] d);
        return (wbw && wbrd != 5'd0 && wbrd == rs) ? wbd : d;
    endfunction

    // One clock of the stage, described as what happens to the instruction slot
    function automatic mstate_t step(input mstate_t s);
        mstate_t n;
        n = s;
        if (fl) begin
            n.valid = 1'b0;
        end else if (v && accepts(s)) begin
            n.valid      = 1'b1;
            n.ins        = cur;
            n.ins.rdata1 = wb_fix(cur.rs1, cur.rdata1);
            n.ins.rdata2 = wb_fix(cur.rs2, cur.rdata2);
        end else if (exr) begin
            n.valid = 1'b0;
            if (waits_on_load(s)) n.cnt = (s.cnt == {CNT_W{1'b1}}) ? s.cnt : s.cnt + 1'b1;
        end else if (s.valid) begin
            n.ins.rdata1 = wb_fix(s.ins.rs1, s.ins.rdata1);
            n.ins.rdata2 = wb_fix(s.ins.rs2, s.ins.rdata2);
        end
        return n;
    endfunction

    function automatic logic [26:0] ctrl_of(input ins_t i);
        return {i.rs1, i.rs2, i.rd, i.alu_op, i.funct, i.reg_write, i.mem_read,
                i.mem_write, i.mem_to_reg, i.alu_src, i.branch};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= '0;
        else        st <= step(st);
    end

    // Cycle compare, just before each rising edge
    always @(negedge clk) begin
        #3;
        if (rst_n && chk_en) begin
            chk("id_ready", 64'(bus.id_ready), 64'(accepts(st)));
            chk("ex_valid", 64'(bus.ex_valid), 64'(st.valid));
            chk("bubble_count", 64'(bus.bubble_count), 64'(st.cnt));
            if (st.valid) begin
                chk("ex_pc", bus.ex_pc, st.ins.pc);
                chk("ex_imm", bus.ex_imm, st.ins.imm);
                chk("ex_rdata1", bus.ex_rdata1, st.ins.rdata1);
                chk("ex_rdata2", bus.ex_rdata2, st.ins.rdata2);
                chk("ex_ctrl", 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_alu_op,
                                    bus.ex_funct, bus.ex_reg_write, bus.ex_mem_read,
                                    bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_alu_src,
                                    bus.ex_branch}), 64'(ctrl_of(st.ins)));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input ins_t i, input logic ready);
        v   = valid;
        cur = i;
        exr = ready;
        #1;
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst_n = 1'b1; v = 1'b0; cur = '0; exr = 1'b1; fl = 1'b0;
        wbw = 1'b0; wbrd = 5'd0; wbd = 64'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst ex_pc", bus.ex_pc, 64'd0);
        chk("rst ex_rdata1", bus.ex_rdata1, 64'd0);
        chk("rst ex_rd", 64'(bus.ex_rd), 64'd0);
        chk("rst bubble_count", 64'(bus.bubble_count), 64'd0);
        chk("rst id_ready", 64'(bus.id_ready), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // streaming
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, alu(64'h100 + 64'(4 * k), 5'(10 + k), 5'd1, 5'd2, 64'(k + 1), 64'(k + 2)), 1'b1);
            chk("stream id_ready", 64'(bus.id_ready), 64'd1);
            tick();
            chk("stream ex_valid", 64'(bus.ex_valid), 64'd1);
            chk("stream ex_pc", bus.ex_pc, 64'h100 + 64'(4 * k));
        end
        drive(1'b0, '0, 1'b1);
        tick();
        chk("stream drained", 64'(bus.ex_valid), 64'd0);
        chk("stream bubbles", 64'(bus.bubble_count), 64'd0);

        // back-pressure with writeback into the stalled rs2
        drive(1'b1, alu(64'h200, 5'd12, 5'd3, 5'd9, 64'h33, 64'h99), 1'b1);
        tick();
        drive(1'b1, alu(64'h204, 5'd13, 5'd1, 5'd2, 64'h1, 64'h2), 1'b0);
        chk("bp id_ready", 64'(bus.id_ready), 64'd0);
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin wbw = 1'b1; wbrd = 5'd9; wbd = 64'h55; end
            tick();
            wbw = 1'b0;
            chk("bp ex_pc stable", bus.ex_pc, 64'h200);
            chk("bp id_ready", 64'(bus.id_ready), 64'd0);
            chk("bp ex_rdata2", bus.ex_rdata2, (s >= 1) ? 64'h55 : 64'h99);
        end
        exr = 1'b1;
        #1;
        chk("bp release id_ready", 64'(bus.id_ready), 64'd1);
        tick();
        chk("bp next ex_pc", bus.ex_pc, 64'h204);
        drive(1'b0, '0, 1'b1);
        tick();

        // load-use: ld x5 ; add x6,x5,x1
        drive(1'b1, ld(64'h300, 5'd5, 5'd1), 1'b1);
        tick();
        drive(1'b1, alu(64'h304, 5'd6, 5'd5, 5'd1, 64'h7, 64'h8), 1'b1);
        chk("lu id_ready", 64'(bus.id_ready), 64'd0);
        tick();
        chk("lu bubble", 64'(bus.ex_valid), 64'd0);
        chk("lu count", 64'(bus.bubble_count), 64'd1);
        tick();
        chk("lu add issued", bus.ex_pc, 64'h304);
        // load to x0 never stalls
        drive(1'b1, ld(64'h310, 5'd0, 5'd1), 1'b1);
        tick();
        drive(1'b1, alu(64'h314, 5'd6, 5'd0, 5'd1, 64'h0, 64'h8), 1'b1);
        chk("lu x0 id_ready", 64'(bus.id_ready), 64'd1);
        tick();
        chk("lu x0 ex_pc", bus.ex_pc, 64'h314);
        chk("lu x0 count", 64'(bus.bubble_count), 64'd1);

        // writeback bypass on capture; x0 never overridden
        wbw = 1'b1; wbrd = 5'd7; wbd = 64'hab;
        drive(1'b1, alu(64'h400, 5'd8, 5'd7, 5'd2, 64'h11, 64'h22), 1'b1);
        tick();
        chk("wb cap rdata1", bus.ex_rdata1, 64'hab);
        chk("wb cap rdata2", bus.ex_rdata2, 64'h22);
        wbrd = 5'd0; wbd = 64'hcc;
        drive(1'b1, alu(64'h404, 5'd8, 5'd0, 5'd2, 64'h77, 64'h22), 1'b1);
        tick();
        chk("wb x0 rdata1", bus.ex_rdata1, 64'h77);
        wbw = 1'b0;

        // flush coinciding with a load-use hazard
        drive(1'b1, ld(64'h500, 5'd5, 5'd1), 1'b1);
        tick();
        fl = 1'b1;
        drive(1'b1, alu(64'h504, 5'd6, 5'd5, 5'd1, 64'h1, 64'h1), 1'b1);
        chk("fl id_ready", 64'(bus.id_ready), 64'd0);
        tick();
        fl = 1'b0;
        chk("fl ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("fl count", 64'(bus.bubble_count), 64'd1);
        // flush of a stalled instruction with a new one offered
        drive(1'b1, alu(64'h510, 5'd9, 5'd1, 5'd2, 64'h1, 64'h2), 1'b1);
        tick();
        chk("fl2 captured", bus.ex_pc, 64'h510);
        fl = 1'b1;
        drive(1'b1, alu(64'h514, 5'd9, 5'd1, 5'd2, 64'h1, 64'h2), 1'b0);
        tick();
        fl = 1'b0;
        chk("fl2 ex_valid", 64'(bus.ex_valid), 64'd0);
        drive(1'b0, '0, 1'b1);
        tick();
        chk("fl2 nothing captured", 64'(bus.ex_valid), 64'd0);

        // saturate the bubble counter
        for (int it = 0; it < 8; it++) begin
            drive(1'b1, ld(64'h600 + 64'(16 * it), 5'd5, 5'd1), 1'b1);
            tick();
            drive(1'b1, alu(64'h604 + 64'(16 * it), 5'd6, 5'd5, 5'd1, 64'h0, 64'h0), 1'b1);
            tick();
            tick();
        end
        chk("sat count", 64'(bus.bubble_count), 64'd7);
        drive(1'b0, '0, 1'b1);
        tick();

        // reset while stalled
        drive(1'b1, alu(64'h700, 5'd10, 5'd1, 5'd2, 64'h5, 64'h6), 1'b1);
        tick();
        drive(1'b1, alu(64'h704, 5'd11, 5'd1, 5'd2, 64'h5, 64'h6), 1'b0);
        tick();
        chk("stall held", bus.ex_pc, 64'h700);
        rst_n = 1'b0;
        #1;
        chk("mid rst ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("mid rst ex_pc", bus.ex_pc, 64'd0);
        chk("mid rst ex_rdata1", bus.ex_rdata1, 64'd0);
        chk("mid rst count", 64'(bus.bubble_count), 64'd0);
        chk("mid rst id_ready", 64'(bus.id_ready), 64'd1);
        drive(1'b1, alu(64'h708, 5'd12, 5'd1, 5'd2, 64'h9, 64'ha), 1'b1);
        rst_n = 1'b1;
        tick();
        chk("post rst ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("post rst ex_pc", bus.ex_pc, 64'h708);
        drive(1'b0, '0, 1'b1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
